timer_counter: RTL and testbench

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_counter_pkg.sv | 39 +++
 rtl/timer_counter.sv | 111 +++++++++++
 tb/tb_timer_counter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_pkg.sv
// Shared definitions for the timer/counter block: FSM state encoding, register
// offsets, CTRL bit positions and the TC1/TC2 bus windows.
package timer_counter_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StCnt  = 2'd2,
      StInt  = 2'd3
   } tc_state_e;

   // Word offsets decoded from Addr[3:2]
   localparam logic [1:0] OffCtrl   = 2'd0;
   localparam logic [1:0] OffPreset = 2'd1;
   localparam logic [1:0] OffCount  = 2'd2;
   localparam logic [1:0] OffRsvd   = 2'd3;

   // CTRL bit positions
   localparam int unsigned CtrlEnBit   = 0;
   localparam int unsigned CtrlModeLsb = 1;
   localparam int unsigned CtrlModeMsb = 2;
   localparam int unsigned CtrlImBit   = 3;

   localparam logic [1:0] ModeOneShot = 2'b00;
   localparam logic [1:0] ModeReload  = 2'b01;

   // Byte address windows decoded by the system bridge
   localparam logic [31:0] Tc1Base = 32'h0000_7f00;
   localparam logic [31:0] Tc1Last = 32'h0000_7f0f;
   localparam logic [31:0] Tc2Base = 32'h0000_7f10;
   localparam logic [31:0] Tc2Last = 32'h0000_7f1f;

   function automatic logic tc_in_window(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] last);
      return (addr >= base) && (addr <= last);
   endfunction

endpackage

// File: rtl/timer_counter.sv
// Programmable down-counting timer with one-shot and auto-reload modes and a
// maskable interrupt. Register file: CTRL, PRESET, COUNT (read-only).
module timer_counter
   import timer_counter_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   tc_state_e   state_q, state_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic [31:0] preset_q, preset_d;
   logic [31:0] count_q, count_d;
   logic        irq_q, irq_d;

   logic [1:0] off;
   logic       en;
   logic [1:0] mode;
   logic       unused_addr;

   assign off         = Addr[3:2];
   assign en          = ctrl_q[CtrlEnBit];
   assign mode        = ctrl_q[CtrlModeMsb:CtrlModeLsb];
   assign unused_addr = ^Addr[31:4];

   // State and register file; reset clears everything immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         ctrl_q   <= 4'd0;
         preset_q <= 32'd0;
         count_q  <= 32'd0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         irq_q    <= irq_d;
      end
   end

   // Next-state: a bus write pre-empts the FSM for that cycle and drops the flag
   always_comb begin
      state_d  = state_q;
      ctrl_d   = ctrl_q;
      preset_d = preset_q;
      count_d  = count_q;
      irq_d    = irq_q;

      if (WE) begin
         irq_d = 1'b0;
         unique case (off)
            OffCtrl:   ctrl_d   = Din[3:0];
            OffPreset: preset_d = Din;
            default:   ;
         endcase
      end else begin
         unique case (state_q)
            StIdle: begin
               if (en) state_d = StLoad;
            end
            StLoad: begin
               count_d = preset_q;
               state_d = StCnt;
            end
            StCnt: begin
               if (!en) begin
                  state_d = StIdle;
               end else if (count_q > 32'd1) begin
                  count_d = count_q - 32'd1;
               end else begin
                  // Covers PRESET=0 as well; never wraps below zero
                  count_d = 32'd0;
                  irq_d   = 1'b1;
                  state_d = StInt;
               end
            end
            StInt: begin
               if (mode == ModeReload) begin
                  irq_d = 1'b0;
               end else begin
                  ctrl_d[CtrlEnBit] = 1'b0;
               end
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Combinational read mux
   always_comb begin
      Dout = 32'd0;
      unique case (off)
         OffCtrl:   Dout = {28'd0, ctrl_q};
         OffPreset: Dout = preset_q;
         OffCount:  Dout = count_q;
         OffRsvd:   Dout = 32'd0;
         default:   Dout = 32'd0;
      endcase
   end

   assign IRQ = ctrl_q[CtrlImBit] & irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed and randomized checks of timer_counter against a behavioural model.
module tb_timer_counter;

   logic        clk;
   logic        reset;
   logic [31:2] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;

   int checks   = 0;
   int failures = 0;

   timer_counter dut (
      .clk  (clk),
      .reset(reset),
      .Addr (Addr),
      .WE   (WE),
      .Din  (Din),
      .Dout (Dout),
      .IRQ  (IRQ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: timer phases as plain integers
   localparam int PhWait  = 0;
   localparam int PhLoad  = 1;
   localparam int PhCount = 2;
   localparam int PhDone  = 3;

   logic [3:0]  m_ctrl;
   logic [31:0] m_preset;
   logic [31:0] m_count;
   logic        m_flag;
   int          m_phase;

   task automatic model_reset();
      m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0; m_phase = PhWait;
   endtask

   task automatic model_step(input logic we, input logic [1:0] off, input logic [31:0] din);
      if (we) begin
         m_flag = 1'b0;
         if (off == 2'd0) m_ctrl = din[3:0];
         else if (off == 2'd1) m_preset = din;
      end else begin
         case (m_phase)
            PhWait: if (m_ctrl[0]) m_phase = PhLoad;
            PhLoad: begin m_count = m_preset; m_phase = PhCount; end
            PhCount: begin
               if (!m_ctrl[0]) m_phase = PhWait;
               else if (m_count > 1) m_count = m_count - 1;
               else begin m_count = 0; m_flag = 1'b1; m_phase = PhDone; end
            end
            default: begin
               if (m_ctrl[2:1] == 2'b01) m_flag = 1'b0;
               else m_ctrl[0] = 1'b0;
               m_phase = PhWait;
            end
         endcase
      end
   endtask

   function automatic logic [31:0] model_read(input logic [1:0] off);
      case (off)
         2'd0:    return {28'd0, m_ctrl};
         2'd1:    return m_preset;
         2'd2:    return m_count;
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle with the given bus inputs; leaves time just after the edge
   task automatic tick(input logic we, input logic [1:0] off, input logic [31:0] din);
      WE = we; Addr = {28'd0, off}; Din = din;
      @(posedge clk);
      model_step(we, off, din);
      #1;
      WE = 1'b0;
   endtask

   task automatic rd(input logic [1:0] off, output logic [31:0] d);
      Addr = {28'd0, off};
      #1;
      d = Dout;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   logic [31:0] rdata;
   int          first;
   logic        irq_hist [0:30];
   logic        seen;

   initial begin
      WE = 1'b0; Addr = '0; Din = '0; reset = 1'b0;
      do_reset();

      // Reset values
      rd(2'd0, rdata); chk("rst_ctrl", rdata, 32'd0);
      rd(2'd1, rdata); chk("rst_preset", rdata, 32'd0);
      rd(2'd2, rdata); chk("rst_count", rdata, 32'd0);
      chk("rst_irq", {31'd0, IRQ}, 32'd0);
      for (int i = 0; i < 4; i++) tick(1'b0, 2'd0, 32'd0);
      rd(2'd2, rdata); chk("idle_count", rdata, 32'd0);

      // One-shot: PRESET=5, CTRL=0x9
      tick(1'b1, 2'd1, 32'd5);
      tick(1'b1, 2'd0, 32'h9);
      first = -1;
      for (int n = 1; n <= 20; n++) begin
         tick(1'b0, 2'd0, 32'd0);
         if (first < 0 && IRQ === 1'b1) first = n;
      end
      chk("oneshot_latency", first, 32'd7);
      chk("oneshot_irq_held", {31'd0, IRQ}, 32'd1);
      rd(2'd0, rdata); chk("oneshot_ctrl", rdata, 32'h8);
      tick(1'b1, 2'd0, 32'h8);
      chk("oneshot_irq_cleared", {31'd0, IRQ}, 32'd0);

      // Auto-reload: PRESET=3, CTRL=0xB
      do_reset();
      tick(1'b1, 2'd1, 32'd3);
      tick(1'b1, 2'd0, 32'hB);
      for (int n = 1; n <= 30; n++) begin
         tick(1'b0, 2'd0, 32'd0);
         irq_hist[n] = IRQ;
         if (n >= 2 && n <= 5) begin
            rd(2'd2, rdata); chk("reload_count", rdata, 32'(5 - n));
         end
      end
      for (int n = 1; n <= 30; n++)
         chk($sformatf("reload_pulse_%0d", n), {31'd0, irq_hist[n]},
             {31'd0, (n >= 5 && ((n - 5) % 6) == 0)});

      // Masked: PRESET=2, CTRL=0x1
      do_reset();
      tick(1'b1, 2'd1, 32'd2);
      tick(1'b1, 2'd0, 32'h1);
      seen = 1'b0;
      for (int n = 0; n < 8; n++) begin
         tick(1'b0, 2'd0, 32'd0);
         seen = seen | IRQ;
      end
      chk("masked_irq", {31'd0, seen}, 32'd0);
      rd(2'd0, rdata); chk("masked_ctrl", rdata, 32'd0);
      tick(1'b1, 2'd0, 32'h8);
      chk("masked_unmask_irq", {31'd0, IRQ}, 32'd0);

      // PRESET=0: a single counting cycle before expiry
      do_reset();
      tick(1'b1, 2'd0, 32'h9);
      first = -1;
      for (int n = 1; n <= 10; n++) begin
         tick(1'b0, 2'd0, 32'd0);
         if (first < 0 && IRQ === 1'b1) first = n;
      end
      chk("preset0_latency", first, 32'd3);

      // Enable cleared mid-count, COUNT write ignored, re-enable reloads
      do_reset();
      tick(1'b1, 2'd1, 32'd10);
      tick(1'b1, 2'd0, 32'h1);
      for (int n = 0; n < 5; n++) tick(1'b0, 2'd0, 32'd0);
      rd(2'd2, rdata); chk("midcnt_count", rdata, 32'd7);
      tick(1'b1, 2'd0, 32'h0);
      for (int n = 0; n < 3; n++) tick(1'b0, 2'd0, 32'd0);
      rd(2'd2, rdata); chk("disable_hold", rdata, 32'd7);
      tick(1'b1, 2'd2, 32'h1234);
      rd(2'd2, rdata); chk("count_write_ignored", rdata, 32'd7);
      tick(1'b1, 2'd0, 32'h1);
      tick(1'b0, 2'd0, 32'd0);
      tick(1'b0, 2'd0, 32'd0);
      rd(2'd2, rdata); chk("reenable_reload", rdata, 32'd10);

      // Asynchronous reset mid-count
      do_reset();
      tick(1'b1, 2'd1, 32'd10);
      tick(1'b1, 2'd0, 32'h9);
      for (int n = 0; n < 7; n++) tick(1'b0, 2'd0, 32'd0);
      rd(2'd2, rdata); chk("prereset_count", rdata, 32'd5);
      reset = 1'b1;
      model_reset();
      #1;
      chk("async_rst_irq", {31'd0, IRQ}, 32'd0);
      rd(2'd2, rdata); chk("async_rst_count", rdata, 32'd0);
      rd(2'd0, rdata); chk("async_rst_ctrl", rdata, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int n = 0; n < 4; n++) tick(1'b0, 2'd0, 32'd0);
      rd(2'd2, rdata); chk("post_rst_idle_count", rdata, 32'd0);

      // Randomized bus traffic against the model
      do_reset();
      for (int n = 0; n < 400; n++) begin
         logic        we;
         logic [1:0]  off;
         logic [31:0] din;
         we  = ($urandom_range(0, 4) == 0);
         off = 2'($urandom_range(0, 3));
         din = (off == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
         tick(we, off, din);
         chk("rand_irq", {31'd0, IRQ}, {31'd0, m_ctrl[3] & m_flag});
         off = 2'($urandom_range(0, 3));
         rd(off, rdata);
         chk($sformatf("rand_rd_off%0d", off), rdata, model_read(off));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
